// File: rtl/cpu_sequencer_if.sv
// Memory-port bundle shared between the multicycle sequencer and the
// unified instruction/data memory.
//   mem_addr  : request address (zero when no request is active)
//   mem_wdata : store data (zero when no request is active)
//   mem_rd    : read request
//   mem_wr    : write request
//   mem_stall : memory cannot accept the request this cycle
//   mem_done  : access complete, mem_rdata valid this cycle
//   mem_rdata : read data
// master = sequencer side, slave = memory side.
interface cpu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rd;
  logic             mem_wr;
  logic             mem_stall;
  logic             mem_done;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_stall, mem_done, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_stall, mem_done, mem_rdata
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle controller for the unpipelined datapath. One memory port is
// shared by instruction fetch and load/store; this block walks each
// instruction through FETCH_REQ/FETCH_WAIT/EXEC/(MEM_REQ/MEM_WAIT)/COMMIT,
// latches the instruction register and load data, and strobes PC update and
// register-file commit. Decode halt/illegal and memory timeouts end in the
// absorbing HALTED / ERROR states until rst.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pc                : fetch address
//   alu_result        : load/store address
//   store_data        : store value
//   dec_mem_read_en   : decode says load
//   dec_mem_write_en  : decode says store
//   dec_halt, dec_err : decode halt / illegal instruction
//   mem               : memory port (master side)
//   ir                : latched instruction for decode
//   mem_rdata_q       : latched load data for writeback
//   pc_we, rf_commit  : one-cycle strobes in COMMIT
//   busy              : state is not IDLE, HALTED or ERROR
//   halted, err       : sticky terminal indications
module cpu_sequencer #(
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] store_data,
  input  logic             dec_mem_read_en,
  input  logic             dec_mem_write_en,
  input  logic             dec_halt,
  input  logic             dec_err,
  cpu_sequencer_if.master  mem,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] mem_rdata_q,
  output logic             pc_we,
  output logic             rf_commit,
  output logic             busy,
  output logic             halted,
  output logic             err
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_REQ  = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_EXEC       = 4'd3,
    ST_MEM_REQ    = 4'd4,
    ST_MEM_WAIT   = 4'd5,
    ST_COMMIT     = 4'd6,
    ST_HALTED     = 4'd7,
    ST_ERROR      = 4'd8
  } state_t;

  // One extra bit so the incremented count can be compared without wrap.
  localparam logic [16:0] MAX_WAIT_C = 17'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [16:0]      wait_inc_s;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] ld_data_q, ld_data_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic             pc_we_q, pc_we_d;
  logic             rf_commit_q, rf_commit_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;

  assign wait_inc_s = {1'b0, wait_cnt_q} + 17'd1;

  // Next-state, datapath latches and wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    ld_data_d  = ld_data_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH_REQ;
      end
      ST_FETCH_REQ: begin
        if (mem.mem_stall) begin
          state_d = ST_FETCH_REQ;
        end else begin
          state_d    = ST_FETCH_WAIT;
          wait_cnt_d = 16'd0;
        end
      end
      ST_FETCH_WAIT: begin
        // A done on the cycle the count would hit MAX_WAIT still completes.
        if (mem.mem_done) begin
          ir_d    = mem.mem_rdata;
          state_d = ST_EXEC;
        end else if (wait_inc_s >= MAX_WAIT_C) begin
          wait_cnt_d = wait_inc_s[15:0];
          state_d    = ST_ERROR;
        end else begin
          wait_cnt_d = wait_inc_s[15:0];
        end
      end
      ST_EXEC: begin
        if (dec_err || (dec_mem_read_en && dec_mem_write_en)) begin
          state_d = ST_ERROR;
        end else if (dec_halt) begin
          state_d = ST_HALTED;
        end else if (dec_mem_read_en || dec_mem_write_en) begin
          state_d = ST_MEM_REQ;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_MEM_REQ: begin
        if (mem.mem_stall) begin
          state_d = ST_MEM_REQ;
        end else begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 16'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem.mem_done) begin
          // Stores leave the previous load data untouched.
          if (dec_mem_read_en) begin
            ld_data_d = mem.mem_rdata;
          end else begin
            ld_data_d = ld_data_q;
          end
          state_d = ST_COMMIT;
        end else if (wait_inc_s >= MAX_WAIT_C) begin
          wait_cnt_d = wait_inc_s[15:0];
          state_d    = ST_ERROR;
        end else begin
          wait_cnt_d = wait_inc_s[15:0];
        end
      end
      ST_COMMIT: begin
        state_d = ST_FETCH_REQ;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they register with it.
  always_comb begin
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    pc_we_d     = 1'b0;
    rf_commit_d = 1'b0;
    if (state_d == ST_FETCH_REQ) begin
      mem_rd_d = 1'b1;
    end else if (state_d == ST_MEM_REQ) begin
      // Ir is stable through MEM_REQ, so decode enables stay valid while stalled.
      mem_rd_d = dec_mem_read_en & ~dec_mem_write_en;
      mem_wr_d = dec_mem_write_en & ~dec_mem_read_en;
    end else if (state_d == ST_COMMIT) begin
      pc_we_d     = 1'b1;
      rf_commit_d = 1'b1;
    end else begin
      mem_rd_d = 1'b0;
    end
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED) && (state_d != ST_ERROR);
    halted_d = (state_d == ST_HALTED);
    err_d    = (state_d == ST_ERROR);
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 16'd0;
      ir_q        <= '0;
      ld_data_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      pc_we_q     <= 1'b0;
      rf_commit_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ir_q        <= ir_d;
      ld_data_q   <= ld_data_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      pc_we_q     <= pc_we_d;
      rf_commit_q <= rf_commit_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  // Address/data follow the live pc/alu_result/store_data and are zero off-request.
  always_comb begin
    if (mem_rd_q || mem_wr_q) begin
      if (state_q == ST_MEM_REQ) begin
        mem.mem_addr  = alu_result;
        mem.mem_wdata = store_data;
      end else begin
        mem.mem_addr  = pc;
        mem.mem_wdata = '0;
      end
    end else begin
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
    end
  end

  assign mem.mem_rd  = mem_rd_q;
  assign mem.mem_wr  = mem_wr_q;
  assign ir          = ir_q;
  assign mem_rdata_q = ld_data_q;
  assign pc_we       = pc_we_q;
  assign rf_commit   = rf_commit_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  localparam int W  = 16;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] pc_r;
  logic [15:0] alu_result, store_data;
  logic        dec_rd, dec_wr, dec_halt, dec_err;
  logic [15:0] ir, rdq;
  logic        pc_we, rf_commit, busy, halted, err;
  logic [2:0]  kind_s;

  cpu_sequencer_if #(.WIDTH(W)) mif ();

  cpu_sequencer #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc_r),
    .alu_result       (alu_result),
    .store_data       (store_data),
    .dec_mem_read_en  (dec_rd),
    .dec_mem_write_en (dec_wr),
    .dec_halt         (dec_halt),
    .dec_err          (dec_err),
    .mem              (mif.master),
    .ir               (ir),
    .mem_rdata_q      (rdq),
    .pc_we            (pc_we),
    .rf_commit        (rf_commit),
    .busy             (busy),
    .halted           (halted),
    .err              (err)
  );

  // Toy decode: ir[2:0] selects the instruction class.
  // 0,6,7 alu; 1 load; 2 store; 3 halt; 4 illegal; 5 load+store (illegal).
  always_comb begin
    kind_s     = ir[2:0];
    dec_rd     = (kind_s == 3'd1) || (kind_s == 3'd5);
    dec_wr     = (kind_s == 3'd2) || (kind_s == 3'd5);
    dec_halt   = (kind_s == 3'd3);
    dec_err    = (kind_s == 3'd4);
    alu_result = ir & 16'hFFF8;
    store_data = ir ^ 16'h0006;
  end

  // PC register of the surrounding datapath.
  always @(posedge clk) begin
    if (rst) pc_r <= 16'h0000;
    else if (pc_we) pc_r <= pc_r + 16'h0001;
    else pc_r <= pc_r;
  end

  int   cyc = 0;
  logic rst_s = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  // Event kinds: 1 read accepted, 2 write accepted, 3 commit, 4 halted, 5 err.
  typedef struct { int kind; int cyc; logic [15:0] a; logic [15:0] b; } ev_t;
  typedef struct { int stall; int wt; bit tmo; logic [15:0] data; } acc_t;
  ev_t  sb_q[$];
  acc_t acc_q[$];

  int checks = 0;
  int errors = 0;

  function automatic ev_t mk(input int k, input int c, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.b = b;
    return e;
  endfunction

  function automatic acc_t mka(input int st, input int wt, input logic [15:0] d);
    acc_t x;
    x.stall = st; x.wt = wt; x.tmo = (wt == 0); x.data = d;
    return x;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    automatic int   phase = 0;
    automatic int   cnt = 0;
    automatic int   wcnt = 0;
    automatic acc_t cur;
    cur = mka(0, 1, 16'h0000);
    mif.mem_stall = 1'b0;
    mif.mem_done  = 1'b0;
    mif.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        phase = 0;
        mif.mem_stall = 1'b0;
        mif.mem_done  = 1'b0;
      end else begin
        if (phase == 0 && (mif.mem_rd || mif.mem_wr) && acc_q.size() > 0) begin
          cur   = acc_q.pop_front();
          cnt   = cur.stall;
          phase = 1;
        end
        mif.mem_rdata = 16'($urandom);
        if (phase == 0) begin
          mif.mem_stall = 1'($urandom);
          mif.mem_done  = 1'($urandom);
        end else if (phase == 1) begin
          // done during a request phase must be ignored
          mif.mem_done = 1'($urandom);
          checks++;
          if (!(mif.mem_rd || mif.mem_wr)) begin
            errors++;
            $display("FAIL req_held cyc=%0d rd=%b wr=%b expected a held request", cyc, mif.mem_rd, mif.mem_wr);
          end
          if (cnt > 0) begin
            mif.mem_stall = 1'b1;
            cnt--;
          end else begin
            mif.mem_stall = 1'b0;
            phase = 2;
            wcnt  = 1;
          end
        end else begin
          mif.mem_stall = 1'($urandom);
          if (!cur.tmo && wcnt == cur.wt) begin
            mif.mem_done  = 1'b1;
            mif.mem_rdata = cur.data;
            phase = 0;
          end else begin
            mif.mem_done = 1'b0;
          end
          wcnt++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic got(input int k, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d a=%h b=%h expected none", k, cyc, a, b);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.a != a || e.b != b) begin
        errors++;
        $display("FAIL event got kind=%0d cyc=%0d a=%h b=%h expected kind=%0d cyc=%0d a=%h b=%h",
                 k, cyc, a, b, e.kind, e.cyc, e.a, e.b);
      end
    end
  endtask

  initial begin
    automatic logic ph = 1'b0;
    automatic logic pe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_s) begin
        checks++;
        if ((mif.mem_rd && mif.mem_wr) ||
            (!mif.mem_rd && !mif.mem_wr && (mif.mem_addr != 16'h0000 || mif.mem_wdata != 16'h0000)) ||
            (pc_we != rf_commit) || ((halted || err) && busy)) begin
          errors++;
          $display("FAIL invariant cyc=%0d rd=%b wr=%b addr=%h wdata=%h pc_we=%b rf_commit=%b busy=%b halted=%b err=%b",
                   cyc, mif.mem_rd, mif.mem_wr, mif.mem_addr, mif.mem_wdata, pc_we, rf_commit, busy, halted, err);
        end
        if ((mif.mem_rd || mif.mem_wr) && !mif.mem_stall)
          got(mif.mem_wr ? 2 : 1, mif.mem_addr, mif.mem_wdata);
        if (pc_we || rf_commit) got(3, ir, rdq);
        if (halted && !ph) got(4, ir, 16'h0000);
        if (err && !pe) got(5, 16'h0000, 16'h0000);
        if (ph || pe) begin
          checks++;
          if ((ph && !halted) || (pe && !err)) begin
            errors++;
            $display("FAIL sticky cyc=%0d halted=%b err=%b expected halted=%b err=%b", cyc, halted, err, ph, pe);
          end
        end
        ph = halted;
        pe = err;
      end else begin
        ph = 1'b0;
        pe = 1'b0;
      end
    end
  end

  // ---------------- reference model / stimulus ----------------
  int          s_cyc;
  logic [15:0] m_pc, m_rdq;
  bit          ended;
  int          exp_term;

  // fw==0 / mw==0 means the memory never answers that access.
  task automatic add_instr(input logic [2:0] k, input logic [12:0] hi, input int fs, input int fw,
                           input int ms, input int mw, input logic [15:0] d);
    logic [15:0] v;
    int e, c;
    if (ended) return;
    v = {hi, k};
    acc_q.push_back(mka(fs, fw, v));
    sb_q.push_back(mk(1, s_cyc + fs, m_pc, 16'h0000));
    if (fw == 0) begin
      sb_q.push_back(mk(5, s_cyc + fs + MW + 1, 16'h0000, 16'h0000));
      ended = 1; exp_term = 5; return;
    end
    e = s_cyc + fs + fw + 1;
    if (k == 3'd4 || k == 3'd5) begin
      sb_q.push_back(mk(5, e + 1, 16'h0000, 16'h0000));
      ended = 1; exp_term = 5; return;
    end
    if (k == 3'd3) begin
      sb_q.push_back(mk(4, e + 1, v, 16'h0000));
      ended = 1; exp_term = 4; return;
    end
    if (k == 3'd1 || k == 3'd2) begin
      acc_q.push_back(mka(ms, mw, d));
      sb_q.push_back(mk(int'(k), e + 1 + ms, v & 16'hFFF8, v ^ 16'h0006));
      if (mw == 0) begin
        sb_q.push_back(mk(5, e + 1 + ms + MW + 1, 16'h0000, 16'h0000));
        ended = 1; exp_term = 5; return;
      end
      if (k == 3'd1) m_rdq = d;
      c = e + 2 + ms + mw;
      sb_q.push_back(mk(3, c, v, m_rdq));
      s_cyc = c + 1;
    end else begin
      sb_q.push_back(mk(3, e + 1, v, m_rdq));
      s_cyc = e + 2;
    end
    m_pc = m_pc + 16'h0001;
  endtask

  task automatic begin_episode();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mif.mem_rd || mif.mem_wr || pc_we || rf_commit || busy || halted || err ||
        ir != 16'h0000 || rdq != 16'h0000 || mif.mem_addr != 16'h0000 || mif.mem_wdata != 16'h0000) begin
      errors++;
      $display("FAIL reset_state rd=%b wr=%b pc_we=%b rf_commit=%b busy=%b halted=%b err=%b ir=%h rdq=%h expected all zero",
               mif.mem_rd, mif.mem_wr, pc_we, rf_commit, busy, halted, err, ir, rdq);
    end
    acc_q.delete();
    sb_q.delete();
    m_pc = 16'h0000; m_rdq = 16'h0000; ended = 0; exp_term = 0;
    #1;
    rst   = 1'b0;
    s_cyc = cyc + 1;
  endtask

  task automatic end_episode();
    for (int i = 0; i < 400 && sb_q.size() > 0; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drained pending=%0d expected 0", sb_q.size());
    end
    checks++;
    if (halted != (exp_term == 4) || err != (exp_term == 5) || busy) begin
      errors++;
      $display("FAIL terminal halted=%b err=%b busy=%b expected halted=%b err=%b busy=0",
               halted, err, busy, exp_term == 4, exp_term == 5);
    end
  endtask

  initial begin
    automatic logic [2:0] alu_k[5] = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
    // ALU, load, stalled store, stalled fetch with late done, halt
    begin_episode();
    add_instr(3'd0, 13'h0800, 0, 1, 0, 0, 16'h0000);
    add_instr(3'd1, 13'h0020, 0, 1, 0, 1, 16'hBEEF);
    add_instr(3'd2, 13'h0246, 0, 1, 3, 2, 16'h5555);
    add_instr(3'd0, 13'h0123, 2, MW, 0, 0, 16'h0000);
    add_instr(3'd3, 13'h0010, 0, 1, 0, 0, 16'h0000);
    end_episode();
    // fetch timeout
    begin_episode();
    add_instr(3'd0, 13'h0001, 0, 0, 0, 0, 16'h0000);
    end_episode();
    // load+store both set
    begin_episode();
    add_instr(3'd0, 13'h0002, 1, 2, 0, 0, 16'h0000);
    add_instr(3'd5, 13'h0003, 0, 1, 0, 0, 16'h0000);
    end_episode();
    // illegal instruction
    begin_episode();
    add_instr(3'd4, 13'h0004, 0, 3, 0, 0, 16'h0000);
    end_episode();
    // load timing out in MEM_WAIT
    begin_episode();
    add_instr(3'd1, 13'h0005, 0, 1, 2, 0, 16'h0000);
    end_episode();
    // store done exactly at MAX_WAIT, then halt
    begin_episode();
    add_instr(3'd2, 13'h0006, 0, 1, 0, MW, 16'h7777);
    add_instr(3'd3, 13'h0007, 0, 1, 0, 0, 16'h0000);
    end_episode();
    // randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      automatic int n = $urandom_range(0, 5);
      automatic int t = $urandom_range(0, 4);
      begin_episode();
      for (int i = 0; i < n; i++)
        add_instr(alu_k[$urandom_range(0, 4)], 13'($urandom), $urandom_range(0, 3), $urandom_range(1, MW),
                  $urandom_range(0, 3), $urandom_range(1, MW), 16'($urandom));
      case (t)
        0: add_instr(3'd3, 13'($urandom), $urandom_range(0, 3), $urandom_range(1, MW), 0, 0, 16'h0000);
        1: add_instr(3'd4, 13'($urandom), $urandom_range(0, 3), $urandom_range(1, MW), 0, 0, 16'h0000);
        2: add_instr(3'd5, 13'($urandom), $urandom_range(0, 3), $urandom_range(1, MW), 0, 0, 16'h0000);
        3: add_instr(3'd0, 13'($urandom), $urandom_range(0, 3), 0, 0, 0, 16'h0000);
        default: add_instr($urandom_range(0, 1) ? 3'd1 : 3'd2, 13'($urandom), $urandom_range(0, 3),
                           $urandom_range(1, MW), $urandom_range(0, 3), 0, 16'h0000);
      endcase
      end_episode();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
